rect_scanout: RTL and testbench

RECT_SCANOUT -- requirements
Module: rect_scanout

---
 rtl/rect_scanout.sv | 166 ++++++++++++++++
 tb/tb_rect_scanout.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_scanout.sv
// Raster timing generator with a frame-synchronous rectangle overlay.
// Every registered output advances only on a pixel strobe. The rectangle
// edges are shadowed at the last pixel of a frame, so any change takes
// effect from the next frame onwards.
module rect_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic [11:0] i_x1,
  input  logic [11:0] i_x2,
  input  logic [11:0] i_y1,
  input  logic [11:0] i_y2,
  input  logic        i_display,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_active,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_animate,
  output logic        o_draw
);

  localparam int unsigned CW = 12;
  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(VT - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Raster counters
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  // Shadowed rectangle description
  logic [CW-1:0] x1_q, x1_d;
  logic [CW-1:0] x2_q, x2_d;
  logic [CW-1:0] y1_q, y1_d;
  logic [CW-1:0] y2_q, y2_d;
  logic          disp_q, disp_d;

  // Output registers
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          active_q, active_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          animate_q, animate_d;
  logic          draw_q, draw_d;

  logic h_wrap_c;
  logic v_wrap_c;
  logic visible_c;
  logic in_rect_c;

  // Decode of the current raster position against timing and rectangle
  always_comb begin
    h_wrap_c  = (h_q == H_LAST);
    v_wrap_c  = (v_q == V_LAST);
    visible_c = (h_q < H_VIS) && (v_q < V_VIS);
    in_rect_c = disp_q &&
                (x1_q <= h_q) && (h_q < x2_q) &&
                (y1_q <= v_q) && (v_q < y2_q);
  end

  // Counter advance and end-of-frame shadow capture
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    y1_d   = y1_q;
    y2_d   = y2_q;
    disp_d = disp_q;
    if (i_pix_stb) begin
      h_d = h_wrap_c ? '0 : h_q + CW'(1);
      if (h_wrap_c) begin
        v_d = v_wrap_c ? '0 : v_q + CW'(1);
      end
      if (h_wrap_c && v_wrap_c) begin
        x1_d   = i_x1;
        x2_d   = i_x2;
        y1_d   = i_y1;
        y2_d   = i_y2;
        disp_d = i_display;
      end
    end
  end

  // Output values for the current position, loaded on a strobe
  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    active_d  = active_q;
    x_d       = x_q;
    y_d       = y_q;
    draw_d    = draw_q;
    animate_d = i_pix_stb && (h_q == '0) && (v_q == V_VIS);
    if (i_pix_stb) begin
      hs_d     = !((h_q >= HS_BEGIN) && (h_q < HS_END));
      vs_d     = !((v_q >= VS_BEGIN) && (v_q < VS_END));
      active_d = visible_c;
      x_d      = h_q;
      y_d      = v_q;
      draw_d   = visible_c && in_rect_c;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      disp_q    <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      active_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      animate_q <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      disp_q    <= disp_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      active_q  <= active_d;
      x_q       <= x_d;
      y_q       <= y_d;
      animate_q <= animate_d;
      draw_q    <= draw_d;
    end
  end

  assign o_hs      = hs_q;
  assign o_vs      = vs_q;
  assign o_active  = active_q;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_animate = animate_q;
  assign o_draw    = draw_q;

endmodule

// File: tb/tb_rect_scanout.sv
// Bench for rect_scanout on a reduced raster: a pixel-index model checked
// every clock, per-frame statistics, and literal expectations.
module tb_rect_scanout;

  localparam int HA = 40, HF = 4, HS = 6, HB = 5;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 55
  localparam int VT = VA + VF + VS + VB;   // 37
  localparam int FT = HT * VT;             // 2035

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_pix_stb = 1'b0;
  logic [11:0] i_x1 = '0, i_x2 = '0, i_y1 = '0, i_y2 = '0;
  logic        i_display = 1'b0;
  logic        o_hs, o_vs, o_active, o_animate, o_draw;
  logic [11:0] o_x, o_y;

  int checks = 0;
  int errors = 0;

  rect_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
    .i_x1(i_x1), .i_x2(i_x2), .i_y1(i_y1), .i_y2(i_y2),
    .i_display(i_display),
    .o_hs(o_hs), .o_vs(o_vs), .o_active(o_active), .o_x(o_x), .o_y(o_y),
    .o_animate(o_animate), .o_draw(o_draw)
  );

  always #5 i_clk = ~i_clk;

  // Model: the n-th strobe after reset shows raster pixel n
  function automatic int col(int p);
    return p % HT;
  endfunction
  function automatic int row(int p);
    return (p / HT) % VT;
  endfunction

  int   pidx;
  int   rx1, rx2, ry1, ry2;
  logic rdisp;
  logic e_hs, e_vs, e_act, e_anim, e_draw, stb_seen;
  logic [11:0] e_x, e_y;

  // Reference model of expected outputs
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pidx <= 0;
      rx1 <= 0; rx2 <= 0; ry1 <= 0; ry2 <= 0; rdisp <= 1'b0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_act <= 1'b0; e_anim <= 1'b0;
      e_draw <= 1'b0; e_x <= '0; e_y <= '0; stb_seen <= 1'b0;
    end else begin
      stb_seen <= i_pix_stb;
      e_anim   <= 1'b0;
      if (i_pix_stb) begin
        e_x    <= 12'(col(pidx));
        e_y    <= 12'(row(pidx));
        e_hs   <= !(col(pidx) >= HA + HF && col(pidx) < HA + HF + HS);
        e_vs   <= !(row(pidx) >= VA + VF && row(pidx) < VA + VF + VS);
        e_act  <= col(pidx) < HA && row(pidx) < VA;
        e_draw <= col(pidx) < HA && row(pidx) < VA && rdisp &&
                  col(pidx) >= rx1 && col(pidx) < rx2 &&
                  row(pidx) >= ry1 && row(pidx) < ry2;
        e_anim <= col(pidx) == 0 && row(pidx) == VA;
        if (pidx % FT == FT - 1) begin
          rx1 <= int'(i_x1); rx2 <= int'(i_x2);
          ry1 <= int'(i_y1); ry2 <= int'(i_y2);
          rdisp <= i_display;
        end
        pidx <= pidx + 1;
      end
    end
  end

  // Per-clock comparison of all outputs against the model
  always @(negedge i_clk) begin
    checks++;
    if ({o_hs, o_vs, o_active, o_animate, o_draw, o_x, o_y} !==
        {e_hs, e_vs, e_act, e_anim, e_draw, e_x, e_y}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got hs%b vs%b act%b anim%b draw%b x%0d y%0d need hs%b vs%b act%b anim%b draw%b x%0d y%0d",
               $time, o_hs, o_vs, o_active, o_animate, o_draw, o_x, o_y,
               e_hs, e_vs, e_act, e_anim, e_draw, e_x, e_y);
    end
  end

  // Per-frame statistics collected from the DUT outputs
  int acc_draw, acc_hs, acc_vs, acc_anim, fx, fy, ax, ay;
  logic got;
  int fr_draw, fr_hs, fr_vs, fr_anim, fr_fx, fr_fy, fr_ax, fr_ay;
  always @(negedge i_clk) begin
    if (i_rst_n && stb_seen) begin
      if (o_x == 12'd0 && o_y == 12'd0) begin
        acc_draw <= int'(o_draw);
        acc_hs   <= int'(!o_hs);
        acc_vs   <= int'(!o_vs);
        acc_anim <= int'(o_animate);
        got      <= o_draw;
        fx       <= o_draw ? int'(o_x) : -1;
        fy       <= o_draw ? int'(o_y) : -1;
      end else begin
        acc_draw <= acc_draw + int'(o_draw);
        acc_hs   <= acc_hs + int'(!o_hs);
        acc_vs   <= acc_vs + int'(!o_vs);
        acc_anim <= acc_anim + int'(o_animate);
        if (o_draw && !got) begin
          got <= 1'b1;
          fx  <= int'(o_x);
          fy  <= int'(o_y);
        end
      end
      if (o_animate) begin
        ax <= int'(o_x);
        ay <= int'(o_y);
      end
      if (o_x == 12'(HT - 1) && o_y == 12'(VT - 1)) begin
        fr_draw <= acc_draw + int'(o_draw);
        fr_hs   <= acc_hs + int'(!o_hs);
        fr_vs   <= acc_vs + int'(!o_vs);
        fr_anim <= acc_anim + int'(o_animate);
        fr_fx   <= fx;
        fr_fy   <= fy;
        fr_ax   <= ax;
        fr_ay   <= ay;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, act, exp);
    end
  endtask

  // n strobes, one every 'stride' clocks; inputs change 2 units after an edge
  task automatic strobes(input int n, input int stride);
    for (int i = 0; i < n; i++) begin
      i_pix_stb = 1'b1;
      @(posedge i_clk); #2;
      i_pix_stb = 1'b0;
      for (int k = 1; k < stride; k++) begin
        @(posedge i_clk); #2;
      end
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_rect(input int x1, input int x2, input int y1,
                          input int y2, input logic d);
    i_x1 = 12'(x1); i_x2 = 12'(x2); i_y1 = 12'(y1); i_y2 = 12'(y2);
    i_display = d;
  endtask

  task automatic chk_frame(input string tag, input int draws, input int x0,
                           input int y0);
    chk({tag, "_draws"}, fr_draw, draws);
    if (draws > 0) begin
      chk({tag, "_first_x"}, fr_fx, x0);
      chk({tag, "_first_y"}, fr_fy, y0);
    end
    chk({tag, "_anim_cnt"}, fr_anim, 1);
  endtask

  task automatic chk_timing(input string tag);
    chk({tag, "_hs_low"}, fr_hs, HS * VT);   // 222
    chk({tag, "_vs_low"}, fr_vs, VS * HT);   // 110
    chk({tag, "_anim_x"}, fr_ax, 0);
    chk({tag, "_anim_y"}, fr_ay, VA);
  endtask

  initial begin
    set_rect(10, 20, 5, 15, 1'b1);
    #1 i_rst_n = 1'b0;
    repeat (3) begin @(posedge i_clk); #2; end
    settle();
    chk("rst_hs", int'(o_hs), 1);
    chk("rst_vs", int'(o_vs), 1);
    chk("rst_active", int'(o_active), 0);
    chk("rst_xy", int'({o_x, o_y}), 0);
    chk("rst_anim_draw", int'({o_animate, o_draw}), 0);
    i_rst_n = 1'b1;

    // Frame 0: shadow still cleared, nothing drawn
    strobes(1, 1); settle();
    chk("first_x", int'(o_x), 0);
    chk("first_y", int'(o_y), 0);
    chk("first_active", int'(o_active), 1);
    chk("first_draw", int'(o_draw), 0);
    strobes(FT - 1, 1); settle();
    chk_frame("f0", 0, 0, 0);
    chk_timing("f0");

    // Frame 1: 10x10 rectangle; x1 moves to 0 mid-frame
    strobes(550, 1);
    i_x1 = 12'd0;
    strobes(FT - 550, 1); settle();
    chk_frame("f1", 100, 10, 5);

    // Frame 2: columns 0..19; queue an empty-width rectangle
    set_rect(12, 12, 0, 30, 1'b1);
    strobes(FT, 1); settle();
    chk_frame("f2", 200, 0, 5);

    // Frame 3: x1 == x2 draws nothing; queue a rectangle clipped at the right
    set_rect(30, 50, 0, 30, 1'b1);
    strobes(FT, 1); settle();
    chk_frame("f3", 0, 0, 0);

    // Frame 4: columns 30..39 on all 30 lines; queue display off
    set_rect(0, 40, 0, 30, 1'b0);
    strobes(FT, 1); settle();
    chk_frame("f4", 300, 30, 0);

    // Frame 5: display off; queue the original rectangle for a slow frame
    set_rect(10, 20, 5, 15, 1'b1);
    strobes(FT, 1); settle();
    chk_frame("f5", 0, 0, 0);

    // Frame 6: strobe every 4th clock
    strobes(FT, 4); settle();
    chk_frame("f6", 100, 10, 5);
    chk_timing("f6");

    // Reset asserted mid-frame, between clock edges
    strobes(1126, 1); settle();
    chk("pre_rst_x", int'(o_x), 25);
    chk("pre_rst_y", int'(o_y), 20);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_hs_vs", int'({o_hs, o_vs}), 3);
    chk("async_rst_act_anim_draw", int'({o_active, o_animate, o_draw}), 0);
    chk("async_rst_xy", int'({o_x, o_y}), 0);
    repeat (2) begin @(posedge i_clk); #2; end
    i_rst_n = 1'b1;
    strobes(1, 1); settle();
    chk("restart_xy", int'({o_x, o_y}), 0);
    chk("restart_active", int'(o_active), 1);
    strobes(2, 1); settle();
    chk("restart_x2", int'(o_x), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
